imem_port_arbiter: RTL and testbench



---
 rtl/imem_arb_pkg.sv | 16 +
 rtl/imem_starve_ctr.sv | 28 ++
 rtl/imem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_arb_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int DEFAULT_ADDR_W = 7;
  localparam int OFS_W          = $clog2(WORD_BYTES);

  typedef enum logic {ARB, LOCK} state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_e;

  function automatic logic is_aligned(input logic [OFS_W-1:0] ofs);
    return ofs == '0;
  endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating event counter: counts inc cycles up to MAX, clr wins over inc.
module imem_starve_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count == W'(MAX));

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter between fetch and program loader.
// Optional lock timeout enabled by defining IMEM_ARB_LOCK_TIMEOUT_EN.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err_misalign,
`ifdef IMEM_ARB_LOCK_TIMEOUT_EN
  output logic              lock_to,
`endif
  output logic              if_stall
);

  state_e state, state_nxt;
  owner_e owner;
  logic   in_lock, lock_ok, starve_sat, gnt_aligned;

  imem_starve_ctr #(.MAX(STARVE_MAX)) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_req & ~if_gnt),
    .clr   (if_gnt | ~if_req),
    .sat   (starve_sat)
  );

`ifdef IMEM_ARB_LOCK_TIMEOUT_EN
  logic lock_sat, relock_block, force_arb;

  // Saturates on the LOCK_MAX-th cycle in LOCK (the entry grant cycle is cycle 0).
  imem_starve_ctr #(.MAX(LOCK_MAX - 1)) u_lock_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == LOCK),
    .clr   (state != LOCK),
    .sat   (lock_sat)
  );

  assign force_arb = (state == LOCK) && lock_sat;
  assign in_lock   = (state == LOCK) && ld_lock && !lock_sat;
  assign lock_ok   = !relock_block && !force_arb;

  // After a timeout the loader must drop ld_lock before it may lock again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_block <= 1'b0;
      lock_to      <= 1'b0;
    end else if (force_arb) begin
      relock_block <= 1'b1;
      lock_to      <= 1'b1;
    end else if (!ld_lock) begin
      relock_block <= 1'b0;
    end
  end
`else
  localparam int unused_lock_max = LOCK_MAX;

  assign in_lock = (state == LOCK) && ld_lock;
  assign lock_ok = 1'b1;
`endif

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    owner     = OWN_NONE;
    state_nxt = ARB;
    if (in_lock) begin
      if (ld_req) owner = OWN_LD;
    end else if (if_req && starve_sat) begin
      owner = OWN_IF;
    end else if (ld_req) begin
      owner = OWN_LD;
    end else if (if_req) begin
      owner = OWN_IF;
    end
    if (in_lock || (owner == OWN_LD && ld_lock && lock_ok)) state_nxt = LOCK;
  end

  assign if_gnt      = (owner == OWN_IF);
  assign ld_gnt      = (owner == OWN_LD);
  assign if_stall    = if_req && !if_gnt;
  assign mem_addr    = ld_gnt ? ld_addr : if_addr;
  assign gnt_aligned = is_aligned(mem_addr[OFS_W-1:0]);
  assign mem_we      = rst_n && ld_gnt && ld_we && gnt_aligned;
  assign mem_wdata   = ld_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB;
      if_rvalid    <= 1'b0;
      ld_rvalid    <= 1'b0;
      if_rdata     <= '0;
      ld_rdata     <= '0;
      err_misalign <= 1'b0;
    end else begin
      state        <= state_nxt;
      if_rvalid    <= if_gnt;
      ld_rvalid    <= ld_gnt;
      err_misalign <= (if_gnt || ld_gnt) && !gnt_aligned;
      if (if_gnt) if_rdata <= gnt_aligned ? mem_rdata : '0;
      // Write completions leave ld_rdata untouched.
      if (ld_gnt && !ld_we) ld_rdata <= gnt_aligned ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed table, reset corners, random vs. model.
module tb_imem_port_arbiter;

  localparam int ADDR_W     = 7;
  localparam int STARVE_MAX = 4;
  localparam int NVEC       = 29;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0, ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0, ld_addr = '0;
  logic [31:0]       ld_wdata = '0;
  logic              if_gnt, if_rvalid, ld_gnt, ld_rvalid, mem_we, err_misalign, if_stall;
  logic [31:0]       if_rdata, ld_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
`ifdef IMEM_ARB_LOCK_TIMEOUT_EN
  logic              lock_to;
`endif

  imem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err_misalign(err_misalign),
`ifdef IMEM_ARB_LOCK_TIMEOUT_EN
    .lock_to(lock_to),
`endif
    .if_stall(if_stall)
  );

  always #5 clk = ~clk;

  // Behavioural big-endian memory attached to the port.
  logic [7:0]        hw_mem [128];
  logic [ADDR_W-1:0] hw_base;
  assign hw_base   = {mem_addr[6:2], 2'b00};
  assign mem_rdata = {hw_mem[hw_base], hw_mem[hw_base + 7'd1], hw_mem[hw_base + 7'd2], hw_mem[hw_base + 7'd3]};
  always @(posedge clk) begin
    if (mem_we) begin
      hw_mem[hw_base]        <= mem_wdata[31:24];
      hw_mem[hw_base + 7'd1] <= mem_wdata[23:16];
      hw_mem[hw_base + 7'd2] <= mem_wdata[15:8];
      hw_mem[hw_base + 7'd3] <= mem_wdata[7:0];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ownership rules, starvation count, pending responses and memory image.
  logic [7:0]  m_mem [128];
  bit          m_locked;
  int          m_starve;
  bit          x_if_rv, x_ld_rv, x_err;
  logic [31:0] x_if_rd, x_ld_rd;

  function automatic logic [31:0] m_word(input logic [6:0] a);
    return {m_mem[a], m_mem[a + 7'd1], m_mem[a + 7'd2], m_mem[a + 7'd3]};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_starve = 0;
    x_if_rv = 0; x_ld_rv = 0; x_err = 0;
    x_if_rd = '0; x_ld_rd = '0;
  endtask

  // One cycle: drive, check at negedge against the model, advance the model, pass the edge.
  task automatic step(input logic i_req, input logic [6:0] i_addr, input logic l_req, input logic l_we,
                      input logic l_lock, input logic [6:0] l_addr, input logic [31:0] l_wdata,
                      output logic g_if, output logic g_ld);
    bit          held, e_if, e_ld, al;
    logic [6:0]  a;
    if_req = i_req; if_addr = i_addr; ld_req = l_req; ld_we = l_we;
    ld_lock = l_lock; ld_addr = l_addr; ld_wdata = l_wdata;
    @(negedge clk);
    held = m_locked && l_lock;
    e_if = 0; e_ld = 0;
    if (held) e_ld = l_req;
    else if (i_req && m_starve == STARVE_MAX) e_if = 1;
    else if (l_req) e_ld = 1;
    else if (i_req) e_if = 1;
    a  = e_ld ? l_addr : i_addr;
    al = (a[1:0] == 2'b00);
    g_if = if_gnt; g_ld = ld_gnt;
    check("if_gnt", 32'(if_gnt), 32'(e_if));
    check("ld_gnt", 32'(ld_gnt), 32'(e_ld));
    check("if_stall", 32'(if_stall), 32'(i_req && !e_if));
    check("mem_we", 32'(mem_we), 32'(e_ld && l_we && al));
    check("mem_addr", 32'(mem_addr), 32'(a));
    check("if_rvalid", 32'(if_rvalid), 32'(x_if_rv));
    check("ld_rvalid", 32'(ld_rvalid), 32'(x_ld_rv));
    check("err_misalign", 32'(err_misalign), 32'(x_err));
    if (x_if_rv) check("if_rdata", if_rdata, x_if_rd);
    if (x_ld_rv) check("ld_rdata", ld_rdata, x_ld_rd);
    x_if_rv = e_if; x_ld_rv = e_ld; x_err = (e_if || e_ld) && !al;
    if (e_if) x_if_rd = al ? m_word(a) : 32'h0;
    if (e_ld && !l_we) x_ld_rd = al ? m_word(a) : 32'h0;
    if (e_ld && l_we && al) begin
      m_mem[a] = l_wdata[31:24]; m_mem[a + 7'd1] = l_wdata[23:16];
      m_mem[a + 7'd2] = l_wdata[15:8]; m_mem[a + 7'd3] = l_wdata[7:0];
    end
    m_locked = held || (e_ld && l_lock);
    if (i_req && !e_if) begin
      if (m_starve < STARVE_MAX) m_starve++;
    end else begin
      m_starve = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b0; ld_addr = 7'h00; if_req = 1'b0;
    #2;
    check("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    check("rst_ld_rvalid", 32'(ld_rvalid), 32'h0);
    check("rst_err", 32'(err_misalign), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_ld_rdata", ld_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ld_req = 1'b0; ld_we = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        i_req;
    logic [6:0]  i_addr;
    logic        l_req, l_we, l_lock;
    logic [6:0]  l_addr;
    logic [31:0] l_wdata;
    logic        e_if, e_ld;
  } vec_t;

  function automatic vec_t mk(input logic i_req, input logic [6:0] i_addr, input logic l_req,
                              input logic l_we, input logic l_lock, input logic [6:0] l_addr,
                              input logic [31:0] l_wdata, input logic e_if, input logic e_ld);
    vec_t v;
    v.i_req = i_req; v.i_addr = i_addr; v.l_req = l_req; v.l_we = l_we; v.l_lock = l_lock;
    v.l_addr = l_addr; v.l_wdata = l_wdata; v.e_if = e_if; v.e_ld = e_ld;
    return v;
  endfunction

  vec_t vec [NVEC];

  initial begin
    logic g_if, g_ld;
    vec[0] = mk(1, 7'h00, 0, 0, 0, 7'h00, 32'h0, 1, 0);
    vec[1] = mk(1, 7'h04, 0, 0, 0, 7'h00, 32'h0, 1, 0);
    vec[2] = mk(1, 7'h08, 0, 0, 0, 7'h00, 32'h0, 1, 0);
    vec[3] = mk(0, 7'h00, 1, 1, 0, 7'h08, 32'h3400_0507, 0, 1);
    vec[4] = mk(1, 7'h08, 0, 0, 0, 7'h00, 32'h0, 1, 0);
    for (int k = 0; k < 10; k++)
      vec[5 + k] = mk(1, 7'h10, 1, 0, 0, 7'h0C, 32'h0, (k % 5) == 4, (k % 5) != 4);
    vec[15] = mk(0, 7'h00, 0, 0, 0, 7'h00, 32'h0, 0, 0);
    for (int k = 0; k < 10; k++)
      vec[16 + k] = mk(1, 7'h00, 1, 1, 1, 7'(7'h40 + 4 * k), 32'hA500_0000 + 32'(k), 0, 1);
    vec[26] = mk(1, 7'h14, 1, 1, 0, 7'h70, 32'h1111_2222, 1, 0);
    vec[27] = mk(0, 7'h00, 1, 1, 0, 7'h05, 32'hDEAD_BEEF, 0, 1);
    vec[28] = mk(1, 7'h04, 0, 0, 0, 7'h00, 32'h0, 1, 0);

    for (int i = 0; i < 128; i++) begin
      hw_mem[i] = 8'($urandom);
      m_mem[i]  = hw_mem[i];
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_if_rvalid", 32'(if_rvalid), 32'h0);
    check("reset_ld_rvalid", 32'(ld_rvalid), 32'h0);
    check("reset_err", 32'(err_misalign), 32'h0);
    check("reset_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      step(vec[i].i_req, vec[i].i_addr, vec[i].l_req, vec[i].l_we, vec[i].l_lock,
           vec[i].l_addr, vec[i].l_wdata, g_if, g_ld);
      check($sformatf("vec%0d_if_gnt", i), 32'(g_if), 32'(vec[i].e_if));
      check($sformatf("vec%0d_ld_gnt", i), 32'(g_ld), 32'(vec[i].e_ld));
      if (i == 4) check("fetch_after_write", if_rdata, 32'h3400_0507);
      if (i == 27) check("misalign_pulse", 32'(err_misalign), 32'h1);
    end
    step(0, 7'h00, 0, 0, 0, 7'h00, 32'h0, g_if, g_ld);

    // Reset in the cycle after a fetch grant drops the pending response.
    step(1, 7'h20, 0, 0, 0, 7'h00, 32'h0, g_if, g_ld);
    do_reset();
    // Reset while locked returns the arbiter to ARB.
    step(0, 7'h00, 1, 1, 1, 7'h30, 32'h0BAD_F00D, g_if, g_ld);
    do_reset();
    step(1, 7'h24, 0, 0, 1, 7'h00, 32'h0, g_if, g_ld);
    check("post_reset_arb", 32'(g_if), 32'h1);

    for (int c = 0; c < 400; c++) begin
      logic [6:0] ia, la;
      ia = {5'($urandom), 2'b00};
      la = {5'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) la[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 3) != 0, ia, 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, la, $urandom, g_if, g_ld);
    end

`ifdef IMEM_ARB_LOCK_TIMEOUT_EN
    begin
      int first_fetch;
      first_fetch = -1;
      if_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if_req = 1'b1; if_addr = 7'h00;
      ld_req = 1'b1; ld_we = 1'b0; ld_lock = 1'b1; ld_addr = 7'h00;
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        if (if_gnt && first_fetch < 0) first_fetch = c;
        if (c == 69) check("no_relock_fetch", 32'(if_gnt), 32'h1);
        @(posedge clk); #1;
      end
      check("lock_timeout_cycle", 32'(first_fetch), 32'd64);
      check("lock_to", 32'(lock_to), 32'h1);
      if_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
